// File: rtl/mul_div_if.sv
// Handshake and HI/LO bus between the execute stage and mul_div_unit.
interface mul_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_wr, lo_wr, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_wr, lo_wr, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// MUL_DIV_FAST_MULT_EN: single-cycle combinational multiply; divide stays iterative.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic     clk,
    input logic     reset,
    mul_div_if.slave bus
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] rem_new;
    logic [W2-1:0]    mul_step, div_step;
    logic [WIDTH-1:0] quo, rem;

    assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    assign abs_a = a_neg ? -bus.a : bus.a;
    assign abs_b = b_neg ? -bus.b : bus.b;

    // Multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Remainder in the high half, dividend shifting out of the low half into quotient bits.
    assign div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    assign rem_new   = div_trial[WIDTH] ? {acc_q[W2-2:WIDTH], acc_q[WIDTH-1]}
                                        : div_trial[WIDTH-1:0];
    assign div_step  = {rem_new, acc_q[WIDTH-2:0], ~div_trial[WIDTH]};

    assign quo = acc_q[WIDTH-1:0];
    assign rem = acc_q[W2-1:WIDTH];

`ifdef MUL_DIV_FAST_MULT_EN
    logic [W2-1:0] fast_prod;
    assign fast_prod = W2'(abs_a) * W2'(abs_b);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.hi_wr) hi_d = bus.wr_data;
                if (bus.lo_wr) lo_d = bus.wr_data;
                if (bus.start) begin
                    is_div_d = bus.op[1];
                    a_d      = bus.a;
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    bzero_d  = (bus.b == '0);
                    opnd_d   = bus.op[1] ? abs_b : abs_a;
                    acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
                    cnt_d    = '0;
`ifdef MUL_DIV_FAST_MULT_EN
                    state_d  = bus.op[1] ? StRun : StFix;
                    if (!bus.op[1]) acc_d = fast_prod;
`else
                    state_d  = StRun;
`endif
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end else if (bzero_q) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = neg_q ? -quo : quo;
                    hi_d = rneg_q ? -rem : rem;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
